// File: rtl/hazard_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_sequencer: forwarding, load-use stall, flush and MDU sequencing   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_sequencer #(
   parameter int CNT_W       = 16,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             ResultSrcE0,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             MduOpE,
   input  logic             mdu_done,
   output logic             mdu_start,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             mdu_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int               TMR_W    = $clog2(MDU_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MDU_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nx;
   logic [TMR_W-1:0] timer;
   logic             timeout;
   logic             lw_stall;

   assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // M-stage result is newer than W, so it wins when both match
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m, input logic [4:0] rd_m,
                                          input logic       wr_w, input logic [4:0] rd_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_RUN;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      timeout  = 1'b0;
      case (state)
         S_RUN: begin
            if (MduOpE && !PCSrcE)
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (mdu_done) begin
               state_nx = S_RUN;
            end else if (timer == TMR_LAST) begin
               timeout  = 1'b1;
               state_nx = S_RUN;
            end
         end
         default: state_nx = S_RUN;
      endcase
   end

   always_comb begin
      mdu_start = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (rst_n) begin
         ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
         ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
         if (state == S_WAIT) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
         end else if (MduOpE && !PCSrcE) begin
            mdu_start = 1'b1;
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
         end else begin
            // a taken branch redirects the PC, so it must not be held by a load-use stall
            StallF = lw_stall && !PCSrcE;
            StallD = lw_stall && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer     <= '0;
         mdu_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (state == S_WAIT)
            timer <= timer + TMR_ONE;
         else
            timer <= '0;
         if (timeout)
            mdu_err <= 1'b1;
         if (StallD && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (FlushD && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// Randomized bench for hazard_sequencer against a cycle-level reference model.
module tb_hazard_sequencer;

   localparam int CNT_W       = 4;
   localparam int MDU_TIMEOUT = 8;
   localparam int CNT_SAT     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MduOpE, mdu_done;
   logic             mdu_start, StallF, StallD, StallE, FlushD, FlushE, mdu_err;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_sequencer #(.CNT_W(CNT_W), .MDU_TIMEOUT(MDU_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MduOpE(MduOpE), .mdu_done(mdu_done),
      .mdu_start(mdu_start), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .mdu_err(mdu_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit m_wait, m_err;
   int m_k, m_scnt, m_fcnt;
   bit e_sd, e_fd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_err = 0; m_k = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic check_outputs();
      bit lw, sf, sd, se, fd, fe, st;
      logic [1:0] fa, fb;
      lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      sf = 0; sd = 0; se = 0; fd = 0; fe = 0; st = 0; fa = 2'b00; fb = 2'b00;
      if (rst_n) begin
         fa = fwd(Rs1E);
         fb = fwd(Rs2E);
         if (m_wait) begin
            sf = 1; sd = 1; se = 1;
         end else if (MduOpE && !PCSrcE) begin
            st = 1; sf = 1; sd = 1; se = 1;
         end else begin
            sf = lw && !PCSrcE; sd = sf; fd = PCSrcE; fe = lw || PCSrcE;
         end
      end
      e_sd = sd; e_fd = fd;
      check_val("ForwardAE", ForwardAE, fa);
      check_val("ForwardBE", ForwardBE, fb);
      check_val("StallF", StallF, sf);
      check_val("StallD", StallD, sd);
      check_val("StallE", StallE, se);
      check_val("FlushD", FlushD, fd);
      check_val("FlushE", FlushE, fe);
      check_val("mdu_start", mdu_start, st);
      check_val("mdu_err", mdu_err, m_err);
      check_val("stall_cnt", stall_cnt, m_scnt);
      check_val("flush_cnt", flush_cnt, m_fcnt);
   endtask

   task automatic model_update();
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_wait) begin
            if (mdu_done) m_wait = 0;
            else if (m_k == MDU_TIMEOUT - 1) begin m_err = 1; m_wait = 0; end
            else m_k++;
         end else if (MduOpE && !PCSrcE) begin
            m_wait = 1; m_k = 0;
         end
         if (e_sd && m_scnt < CNT_SAT) m_scnt++;
         if (e_fd && m_fcnt < CNT_SAT) m_fcnt++;
      end
   endtask

   // inputs are set just after a rising edge; outputs checked mid-cycle
   task automatic step();
      #3;
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MduOpE, mdu_done} = '0;
   endtask

   task automatic random_inputs(input int done_pct);
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      RegWriteM   = ($urandom_range(0, 1) == 0);
      RegWriteW   = ($urandom_range(0, 1) == 0);
      PCSrcE      = ($urandom_range(0, 4) == 0);
      MduOpE      = ($urandom_range(0, 7) == 0);
      mdu_done    = ($urandom_range(0, 99) < done_pct);
   endtask

   // asynchronous reset asserted between clock edges, held over one edge
   task automatic pulse_reset();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt_se, cnt_st;
      clear_inputs();
      model_reset();
      random_inputs(50);
      #2;
      check_outputs();
      @(posedge clk); model_update(); #1;
      rst_n = 1'b1;

      // forwarding priority
      clear_inputs();
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1;
      #1; check_val("fwdA_from_M", ForwardAE, 2'b10);
      step();
      RdM = 5'd0;
      #1; check_val("fwdA_from_W", ForwardAE, 2'b01);
      step();

      // load-use stall
      clear_inputs();
      ResultSrcE0 = 1; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      check_val("lu_StallF", StallF, 1);
      check_val("lu_FlushE", FlushE, 1);
      step();
      clear_inputs();
      #1; check_val("lu_stall_cnt", stall_cnt, 1);
      step();

      // load-use plus taken branch
      ResultSrcE0 = 1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1;
      #1;
      check_val("lub_StallD", StallD, 0);
      check_val("lub_FlushD", FlushD, 1);
      step();
      clear_inputs();
      #1; check_val("lub_flush_cnt", flush_cnt, 1);
      step();

      // MDU op with done in the fifth wait cycle
      cnt_se = 0; cnt_st = 0;
      MduOpE = 1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (StallE) cnt_se++;
         if (mdu_start) cnt_st++;
         if (i == 5) mdu_done = 1;
         step();
         MduOpE = 0; mdu_done = 0;
         if (i >= 6 && !StallE) break;
      end
      check_val("mdu_stallE_cycles", cnt_se, 6);
      check_val("mdu_start_cycles", cnt_st, 1);

      // MDU timeout
      MduOpE = 1;
      step();
      MduOpE = 0;
      for (int i = 0; i < MDU_TIMEOUT; i++) step();
      #1;
      check_val("timeout_err", mdu_err, 1);
      check_val("timeout_run", StallE, 0);
      for (int i = 0; i < 3; i++) step();

      // reset in the middle of a wait
      MduOpE = 1;
      step();
      MduOpE = 0;
      step(); step();
      pulse_reset();
      check_val("rst_run_StallE", StallE, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         random_inputs((i / 500) % 2 == 0 ? 25 : 0);
         if ($urandom_range(0, 299) == 0) pulse_reset();
         else step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
